// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared definitions for the RV32 hazard/forwarding control block:
// forwarding select codes, FSM state encoding and the register index width.
package hazard_forward_ctrl_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_IDEX  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  // The younger EX/MEM result always shadows the older MEM/WB value.
  function automatic logic [1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
    if (mem_hit) begin
      return FWD_EXMEM;
    end
    if (wb_hit) begin
      return FWD_MEMWB;
    end
    return FWD_IDEX;
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// Priority compare producing the ALU forwarding select for one EX operand.
// x0 is hard-wired zero and is never forwarded.
module fwd_select
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int REG_AW = hazard_forward_ctrl_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  output logic [1:0]        sel
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs);
  assign wb_hit  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == ex_rs);
  assign sel     = fwd_pick(mem_hit, wb_hit);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forwarding, load-use stall, branch flush and memory-wait freeze control for
// the 5-stage RV32 pipeline. Define HAZARD_PERF_CNT_EN to add perf counters.
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int REG_AW = hazard_forward_ctrl_pkg::REG_AW
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] ID_rs1_i,
  input  logic [REG_AW-1:0] ID_rs2_i,
  input  logic [REG_AW-1:0] EX_rs1_i,
  input  logic [REG_AW-1:0] EX_rs2_i,
  input  logic [REG_AW-1:0] EX_rd_i,
  input  logic              EX_MemRead_i,
  input  logic [REG_AW-1:0] MEM_rd_i,
  input  logic              MEM_RegWrite_i,
  input  logic              MEM_req_i,
  input  logic              mem_ack_i,
  input  logic [REG_AW-1:0] WB_rd_i,
  input  logic              WB_RegWrite_i,
  input  logic              branch_taken_i,
  output logic [1:0]        ForwardA_o,
  output logic [1:0]        ForwardB_o,
  output logic              PCWrite_o,
  output logic              IFID_Write_o,
  output logic              IDEX_Bubble_o,
  output logic              IFID_Flush_o,
  output logic              Freeze_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  lu_cnt_o,
  output logic [CNT_W-1:0]  frz_cnt_o
`endif
);

  state_e     state_q;
  state_e     state_d;
  logic       freeze;
  logic       load_use;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .ex_rs         (EX_rs1_i),
    .mem_rd        (MEM_rd_i),
    .mem_reg_write (MEM_RegWrite_i),
    .wb_rd         (WB_rd_i),
    .wb_reg_write  (WB_RegWrite_i),
    .sel           (fwd_a)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .ex_rs         (EX_rs2_i),
    .mem_rd        (MEM_rd_i),
    .mem_reg_write (MEM_RegWrite_i),
    .wb_rd         (WB_rd_i),
    .wb_reg_write  (WB_RegWrite_i),
    .sel           (fwd_b)
  );

  assign load_use = EX_MemRead_i && (EX_rd_i != '0) &&
                    ((EX_rd_i == ID_rs1_i) || (EX_rd_i == ID_rs2_i));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Freeze drops in the ack cycle itself so the pipeline advances on that edge.
  always_comb begin
    state_d = state_q;
    freeze  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (MEM_req_i && !mem_ack_i) begin
          state_d = ST_MEM_WAIT;
          freeze  = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack_i) begin
          state_d = ST_RUN;
        end else begin
          freeze = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Priority freeze > load-use > flush; reset forces the idle pattern.
  always_comb begin
    ForwardA_o    = FWD_IDEX;
    ForwardB_o    = FWD_IDEX;
    PCWrite_o     = 1'b1;
    IFID_Write_o  = 1'b1;
    IDEX_Bubble_o = 1'b0;
    IFID_Flush_o  = 1'b0;
    Freeze_o      = 1'b0;
    if (!rst_i) begin
      ForwardA_o = fwd_a;
      ForwardB_o = fwd_b;
      if (freeze) begin
        Freeze_o     = 1'b1;
        PCWrite_o    = 1'b0;
        IFID_Write_o = 1'b0;
      end else if (load_use) begin
        PCWrite_o     = 1'b0;
        IFID_Write_o  = 1'b0;
        IDEX_Bubble_o = 1'b1;
      end else if (branch_taken_i) begin
        IFID_Flush_o = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lu_cnt_o  <= '0;
      frz_cnt_o <= '0;
    end else begin
      if (IDEX_Bubble_o) begin
        lu_cnt_o <= sat_inc(lu_cnt_o);
      end
      if (Freeze_o) begin
        frz_cnt_o <= sat_inc(frz_cnt_o);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: vector table for the combinational
// paths plus hand sequences for stall, memory wait and reset-in-wait.
module tb_hazard_forward_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [4:0] ID_rs1_i, ID_rs2_i, EX_rs1_i, EX_rs2_i, EX_rd_i;
  logic       EX_MemRead_i;
  logic [4:0] MEM_rd_i;
  logic       MEM_RegWrite_i, MEM_req_i, mem_ack_i;
  logic [4:0] WB_rd_i;
  logic       WB_RegWrite_i, branch_taken_i;
  logic [1:0] ForwardA_o, ForwardB_o;
  logic       PCWrite_o, IFID_Write_o, IDEX_Bubble_o, IFID_Flush_o, Freeze_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_cnt_o, frz_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  hazard_forward_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ID_rs1_i       (ID_rs1_i),
    .ID_rs2_i       (ID_rs2_i),
    .EX_rs1_i       (EX_rs1_i),
    .EX_rs2_i       (EX_rs2_i),
    .EX_rd_i        (EX_rd_i),
    .EX_MemRead_i   (EX_MemRead_i),
    .MEM_rd_i       (MEM_rd_i),
    .MEM_RegWrite_i (MEM_RegWrite_i),
    .MEM_req_i      (MEM_req_i),
    .mem_ack_i      (mem_ack_i),
    .WB_rd_i        (WB_rd_i),
    .WB_RegWrite_i  (WB_RegWrite_i),
    .branch_taken_i (branch_taken_i),
    .ForwardA_o     (ForwardA_o),
    .ForwardB_o     (ForwardB_o),
    .PCWrite_o      (PCWrite_o),
    .IFID_Write_o   (IFID_Write_o),
    .IDEX_Bubble_o  (IDEX_Bubble_o),
    .IFID_Flush_o   (IFID_Flush_o),
    .Freeze_o       (Freeze_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .lu_cnt_o       (lu_cnt_o),
    .frz_cnt_o      (frz_cnt_o)
`endif
  );

  // Expected pattern packing: {ForwardA, ForwardB, PCWrite, IFID_Write, Bubble, Flush, Freeze}
  localparam logic [8:0] IDLE = 9'b00_00_11000;
  localparam logic [8:0] BUBL = 9'b00_00_00100;
  localparam logic [8:0] FLSH = 9'b00_00_11010;
  localparam logic [8:0] FRZ  = 9'b00_00_00001;

  typedef struct {
    string      name;
    logic [4:0] id1, id2, ex1, ex2, exrd;
    logic       exmr;
    logic [4:0] mrd;
    logic       mrw, req, ack;
    logic [4:0] wrd;
    logic       wrw, br;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(string n, logic [4:0] id1, logic [4:0] id2,
                              logic [4:0] ex1, logic [4:0] ex2, logic [4:0] exrd,
                              logic exmr, logic [4:0] mrd, logic mrw, logic req,
                              logic ack, logic [4:0] wrd, logic wrw, logic br,
                              logic [8:0] exp);
    vec_t v;
    v.name = n; v.id1 = id1; v.id2 = id2; v.ex1 = ex1; v.ex2 = ex2;
    v.exrd = exrd; v.exmr = exmr; v.mrd = mrd; v.mrw = mrw; v.req = req;
    v.ack = ack; v.wrd = wrd; v.wrw = wrw; v.br = br; v.exp = exp;
    return v;
  endfunction

  function automatic logic [8:0] outs();
    return {ForwardA_o, ForwardB_o, PCWrite_o, IFID_Write_o,
            IDEX_Bubble_o, IFID_Flush_o, Freeze_o};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic clear_inputs();
    ID_rs1_i = 0; ID_rs2_i = 0; EX_rs1_i = 0; EX_rs2_i = 0; EX_rd_i = 0;
    EX_MemRead_i = 0; MEM_rd_i = 0; MEM_RegWrite_i = 0; MEM_req_i = 0;
    mem_ack_i = 0; WB_rd_i = 0; WB_RegWrite_i = 0; branch_taken_i = 0;
  endtask

  task automatic drive(input vec_t v);
    ID_rs1_i = v.id1; ID_rs2_i = v.id2; EX_rs1_i = v.ex1; EX_rs2_i = v.ex2;
    EX_rd_i = v.exrd; EX_MemRead_i = v.exmr; MEM_rd_i = v.mrd;
    MEM_RegWrite_i = v.mrw; MEM_req_i = v.req; mem_ack_i = v.ack;
    WB_rd_i = v.wrd; WB_RegWrite_i = v.wrw; branch_taken_i = v.br;
  endtask

  initial begin
    //                name          id1 id2 ex1 ex2 exrd mr  mrd mrw req ack wrd wrw br  expected
    vecs[0]  = mk("both_match",    0,  0,  5,  7,  0,  0,  5,  1,  0,  0,  5,  1,  0,  9'b01_00_11000);
    vecs[1]  = mk("wb_only_b",     0,  0,  5,  7,  0,  0,  5,  1,  0,  0,  7,  1,  0,  9'b01_10_11000);
    vecs[2]  = mk("x0_guard",      0,  0,  0,  0,  0,  0,  0,  1,  0,  0,  0,  1,  0,  IDLE);
    vecs[3]  = mk("mem_nowrite",   0,  0,  5,  5,  0,  0,  5,  0,  0,  0,  5,  1,  0,  9'b10_10_11000);
    vecs[4]  = mk("no_write",      0,  0,  5,  5,  0,  0,  5,  0,  0,  0,  5,  0,  0,  IDLE);
    vecs[5]  = mk("mem_b_wb_a",    0,  0,  5,  9,  0,  0,  9,  1,  0,  0,  5,  1,  0,  9'b10_01_11000);
    vecs[6]  = mk("lu_rs2",        1,  3,  0,  0,  3,  1,  0,  0,  0,  0,  0,  0,  0,  BUBL);
    vecs[7]  = mk("lu_rs1",        3,  4,  0,  0,  3,  1,  0,  0,  0,  0,  0,  0,  0,  BUBL);
    vecs[8]  = mk("lu_x0",         0,  0,  0,  0,  0,  1,  0,  0,  0,  0,  0,  0,  0,  IDLE);
    vecs[9]  = mk("no_load",       0,  3,  0,  0,  3,  0,  0,  0,  0,  0,  0,  0,  0,  IDLE);
    vecs[10] = mk("branch",        0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  1,  FLSH);
    vecs[11] = mk("lu_and_branch", 3,  0,  0,  0,  3,  1,  0,  0,  0,  0,  0,  0,  1,  BUBL);
    vecs[12] = mk("ack_same_cyc",  0,  0,  0,  0,  0,  0,  0,  0,  1,  1,  0,  0,  1,  FLSH);

    // Reset: hazards and forwarding matches present, outputs must still be idle.
    clear_inputs();
    EX_rs1_i = 5; MEM_rd_i = 5; MEM_RegWrite_i = 1;
    EX_MemRead_i = 1; EX_rd_i = 3; ID_rs1_i = 3; branch_taken_i = 1;
    MEM_req_i = 1;
    repeat (2) @(negedge clk_i);
    #1 check("reset_idle", 32'(outs()), 32'(IDLE));
    @(negedge clk_i);
    rst_i = 1'b0;
    clear_inputs();

    for (int i = 0; i < 13; i++) begin
      @(negedge clk_i);
      drive(vecs[i]);
      #1 check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
    end

    // Load-use: one bubble, then the load sits in MEM and the stall clears.
    @(negedge clk_i);
    clear_inputs();
    EX_MemRead_i = 1; EX_rd_i = 3; ID_rs2_i = 3;
    #1 check("lu_seq_stall", 32'(outs()), 32'(BUBL));
    @(negedge clk_i);
    EX_MemRead_i = 0; EX_rd_i = 0; MEM_rd_i = 3; MEM_RegWrite_i = 1;
    #1 check("lu_seq_release", 32'(outs()), 32'(IDLE));
`ifdef HAZARD_PERF_CNT_EN
    check("lu_cnt", lu_cnt_o, 32'd4);
`endif

    // Memory wait: three frozen cycles, ack in the fourth.
    @(negedge clk_i);
    clear_inputs();
    MEM_req_i = 1;
    #1 check("wait_c1", 32'(outs()), 32'(FRZ));
    @(negedge clk_i);
    EX_MemRead_i = 1; EX_rd_i = 3; ID_rs1_i = 3;
    MEM_rd_i = 6; MEM_RegWrite_i = 1; EX_rs1_i = 6;
    #1 check("wait_c2_lu_fwd", 32'(outs()), 32'(9'b01_00_00001));
    @(negedge clk_i);
    clear_inputs();
    MEM_req_i = 1;
    #1 check("wait_c3", 32'(outs()), 32'(FRZ));
    @(negedge clk_i);
    mem_ack_i = 1;
    #1 check("wait_c4_ack", 32'(outs()), 32'(IDLE));
    @(negedge clk_i);
    clear_inputs();
    #1 check("wait_back_run", 32'(outs()), 32'(IDLE));
`ifdef HAZARD_PERF_CNT_EN
    check("frz_cnt", frz_cnt_o, 32'd3);
    check("lu_cnt_frozen", lu_cnt_o, 32'd4);
`endif

    // Reset asserted in MEM_WAIT clears the freeze without a clock edge.
    @(negedge clk_i);
    MEM_req_i = 1;
    @(negedge clk_i);
    #1 check("rst_pre_wait", 32'(Freeze_o), 32'd1);
    rst_i = 1'b1;
    #1 check("rst_async_clear", 32'(outs()), 32'(IDLE));
    @(negedge clk_i);
    rst_i = 1'b0;
    clear_inputs();
    #1 check("rst_after_run", 32'(outs()), 32'(IDLE));
`ifdef HAZARD_PERF_CNT_EN
    check("rst_lu_cnt", lu_cnt_o, 32'd0);
    check("rst_frz_cnt", frz_cnt_o, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
Control block for the 5-stage RV32 pipeline. It generates the 2-bit forwarding selects for the ALU operand forwarding muxes (A and B), detects load-use hazards, and inserts bubbles. It flushes IF/ID on taken branches and freezes the whole pipeline while the data memory is busy, using a small FSM.

Parameters:
REG_AW, 5, register index width
CNT_W, 32, width of the performance counters (optional feature only)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
ID_rs1_i, ID_rs2_i  in  REG_AW  source registers of the instruction in ID (IF/ID register)
EX_rs1_i, EX_rs2_i  in  REG_AW  source registers held in ID/EX
EX_rd_i  in  REG_AW  destination register in ID/EX
EX_MemRead_i  in  1  ID/EX instruction is a load
MEM_rd_i  in  REG_AW  destination register in EX/MEM
MEM_RegWrite_i  in  1  EX/MEM writes the register file
MEM_req_i  in  1  EX/MEM instruction accesses data memory this cycle
mem_ack_i  in  1  data memory completes the access this cycle
WB_rd_i  in  REG_AW  destination register in MEM/WB
WB_RegWrite_i  in  1  MEM/WB writes the register file
branch_taken_i  in  1  branch resolved taken in ID
ForwardA_o, ForwardB_o  out  2  operand selects: 00 = ID/EX register data, 01 = EX/MEM result, 10 = MEM/WB write-back data; 11 is never driven
PCWrite_o  out  1  PC update enable
IFID_Write_o  out  1  IF/ID register enable
IDEX_Bubble_o  out  1  zero the control bits loaded into ID/EX
IFID_Flush_o  out  1  load a NOP into IF/ID
Freeze_o  out  1  hold every pipeline register and the PC

Behaviour:
- Forwarding (combinational, per operand X in {rs1, rs2}):
  - If MEM_RegWrite_i, MEM_rd_i != 0 and MEM_rd_i == EX_X, select 01.
  - Else if WB_RegWrite_i, WB_rd_i != 0 and WB_rd_i == EX_X, select 10.
  - Else select 00.
  - EX/MEM wins when both stages match. Register x0 is never forwarded.
- Load-use: lu = EX_MemRead_i and EX_rd_i != 0 and (EX_rd_i == ID_rs1_i or EX_rd_i == ID_rs2_i).
- FSM states: RUN, MEM_WAIT. Reset state is RUN.
  - RUN -> MEM_WAIT when MEM_req_i and not mem_ack_i.
  - MEM_WAIT -> RUN when mem_ack_i.
  - MEM_WAIT holds otherwise.
  - A single-cycle access (ack in the request cycle) never leaves RUN.
- Freeze_o = (RUN and MEM_req_i and not mem_ack_i) or (MEM_WAIT and not mem_ack_i).
  - The freeze drops combinationally in the ack cycle, so the pipeline advances on that edge.
- Output priority: freeze > load-use > flush.
  - Freeze: PCWrite_o = 0, IFID_Write_o = 0, IDEX_Bubble_o = 0, IFID_Flush_o = 0.
  - Load-use (no freeze): PCWrite_o = 0, IFID_Write_o = 0, IDEX_Bubble_o = 1, IFID_Flush_o = 0. The branch is held in ID and re-evaluated next cycle.
  - branch_taken_i (no freeze, no load-use): IFID_Flush_o = 1; PCWrite_o = 1, IFID_Write_o = 1.
  - Idle: PCWrite_o = 1, IFID_Write_o = 1, IDEX_Bubble_o = 0, IFID_Flush_o = 0.
- Load-use stall length: exactly one cycle per hazard. On the next edge the load moves to MEM, so lu falls naturally.
- Forward selects stay valid during freeze; they are a function of held inputs.
- While rst_i is high:
  - State is forced to RUN.
  - Outputs are forced to idle values: Forward 00, PCWrite_o = 1, IFID_Write_o = 1, IDEX_Bubble_o = 0, IFID_Flush_o = 0, Freeze_o = 0.
  - A reset asserted in MEM_WAIT clears the freeze asynchronously.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs lu_cnt_o[CNT_W] and frz_cnt_o[CNT_W].
  - lu_cnt_o increments on each edge where a load-use bubble is inserted.
  - frz_cnt_o increments on each edge where Freeze_o = 1.
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent; other behaviour is identical.

Decomposition:
- Shared package: forwarding select constants FWD_IDEX = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10; FSM state encoding; REG_AW.
- One natural sub-module: fwd_select, the combinational priority compare for one operand, instantiated twice (A and B).

Test Plan:
- Both ALU-hazard stages match: MEM_rd = 5, RegWrite = 1; WB_rd = 5, RegWrite = 1; EX_rs1 = 5; EX_rs2 = 7 with WB_rd = 7 → ForwardA = 01 (MEM wins); then WB-only match → ForwardB = 10.
- x0 guard: MEM_rd = 0, MEM_RegWrite = 1, EX_rs1 = 0 → ForwardA = 00.
- Load-use: EX_MemRead = 1, EX_rd = 3, ID_rs2 = 3 → one cycle of PCWrite = 0, IFID_Write = 0, IDEX_Bubble = 1; next cycle (load in MEM) returns to idle.
- Memory wait: MEM_req = 1, mem_ack = 0 for 3 cycles, ack on cycle 4 → Freeze_o high for cycles 1–3 and low in cycle 4; state returns to RUN. With HAZARD_PERF_CNT_EN, frz_cnt_o = 3.
- Priority: load-use and branch_taken together → bubble, no flush; freeze and load-use together → freeze only, IDEX_Bubble = 0.
- Reset in MEM_WAIT: assert rst_i mid-wait → Freeze_o = 0 immediately; after release with MEM_req = 0, state is RUN and counters are 0.
